// File: rtl/as_rv32i_memoryaccess.sv
// Memory-access stage of the rv32i pipeline.
// Issues one load/store at a time on a pipelined Wishbone-style bus and
// lane-aligns store data. Loads are sign/zero-extended into o_data_load.
// The stage forwards writeback fields and stalls upstream while an access
// is outstanding.
//
// state  | meaning
// -------+-----------------------------------------------------------
// S_IDLE | no access outstanding; may accept a new instruction
// S_REQ  | strobe asserted, waiting for the bus to take the request
// S_WAIT | request taken, cycle held open until acknowledge
module as_rv32i_memoryaccess (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic [2:0]  i_funct3,
  input  logic        i_opcode_load,
  input  logic        i_opcode_store,
  input  logic        i_opcode_system,
  input  logic [31:0] i_y,
  input  logic [31:0] i_rs2,
  input  logic        i_wr_rd,
  input  logic [4:0]  i_rd_addr,
  input  logic [31:0] i_rd,
  input  logic [31:0] i_pc,
  output logic [2:0]  o_funct3,
  output logic        o_opcode_load,
  output logic        o_opcode_system,
  output logic        o_wr_rd,
  output logic [4:0]  o_rd_addr,
  output logic [31:0] o_rd,
  output logic [31:0] o_pc,
  output logic [31:0] o_data_load,
  output logic        o_wb_cyc,
  output logic        o_wb_stb,
  output logic        o_wb_we,
  output logic [31:0] o_wb_addr,
  output logic [31:0] o_wb_data,
  output logic [3:0]  o_wb_sel,
  input  logic        i_wb_ack,
  input  logic        i_wb_stall,
  input  logic [31:0] i_wb_data,
  input  logic        i_ce,
  output logic        o_ce,
  input  logic        i_stall,
  output logic        o_stall,
  input  logic        i_flush,
  output logic        o_flush
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT} state_t;

  state_t      state;
  logic        discard;
  logic [1:0]  byte_off;
  logic        is_mem;
  logic        accept;
  logic        bus_done;
  logic [3:0]  sel_next;
  logic [31:0] data_next;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] load_ext;

  assign o_stall  = i_stall | (state != S_IDLE);
  assign o_flush  = i_flush;
  assign is_mem   = i_opcode_load | i_opcode_store;
  assign accept   = i_ce & ~o_stall & ~i_flush;
  // Ack is only meaningful once the strobe has been taken (same cycle allowed).
  assign bus_done = i_wb_ack & ((state == S_WAIT) | ((state == S_REQ) & ~i_wb_stall));

  // Byte selects and replicated store lanes for the incoming instruction.
  always_comb begin
    sel_next  = 4'b1111;
    data_next = i_rs2;
    case (i_funct3[1:0])
      2'b00: begin
        sel_next  = 4'b0001 << i_y[1:0];
        data_next = {4{i_rs2[7:0]}};
      end
      2'b01: begin
        sel_next  = i_y[1] ? 4'b1100 : 4'b0011;
        data_next = {2{i_rs2[15:0]}};
      end
      default: ;
    endcase
  end

  // Extend returning load data using the offset and size captured at accept.
  always_comb begin
    ld_byte = i_wb_data[7:0];
    case (byte_off)
      2'd1:    ld_byte = i_wb_data[15:8];
      2'd2:    ld_byte = i_wb_data[23:16];
      2'd3:    ld_byte = i_wb_data[31:24];
      default: ld_byte = i_wb_data[7:0];
    endcase
    ld_half = byte_off[1] ? i_wb_data[31:16] : i_wb_data[15:0];
    case (o_funct3)
      3'b000:  load_ext = {{24{ld_byte[7]}}, ld_byte};
      3'b100:  load_ext = {24'h000000, ld_byte};
      3'b001:  load_ext = {{16{ld_half[15]}}, ld_half};
      3'b101:  load_ext = {16'h0000, ld_half};
      default: load_ext = i_wb_data;
    endcase
  end

  // Forwarded fields and bus address/data; only move on an accepted instruction.
  always_ff @(posedge i_clk) begin
    if (accept) begin
      o_funct3        <= i_funct3;
      o_opcode_load   <= i_opcode_load;
      o_opcode_system <= i_opcode_system;
      o_rd_addr       <= i_rd_addr;
      o_rd            <= i_rd;
      o_pc            <= i_pc;
      if (is_mem) begin
        o_wb_addr <= {i_y[31:2], 2'b00};
        o_wb_data <= data_next;
        byte_off  <= i_y[1:0];
      end
    end
  end

  // Bus FSM, clock-enable and writeback-visible control.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state       <= S_IDLE;
      discard     <= 1'b0;
      o_wb_cyc    <= 1'b0;
      o_wb_stb    <= 1'b0;
      o_wb_we     <= 1'b0;
      o_wb_sel    <= 4'b0000;
      o_ce        <= 1'b0;
      o_wr_rd     <= 1'b0;
      o_data_load <= 32'h0;
    end else if (i_flush) begin
      o_ce    <= 1'b0;
      o_wr_rd <= 1'b0;
      case (state)
        S_REQ: begin
          // Request not yet committed: abandon it so no store lands.
          o_wb_cyc <= 1'b0;
          o_wb_stb <= 1'b0;
          state    <= S_IDLE;
        end
        S_WAIT: begin
          // Slave already owns the request; finish the cycle but drop its result.
          if (i_wb_ack) begin
            o_wb_cyc <= 1'b0;
            o_wb_we  <= 1'b0;
            discard  <= 1'b0;
            state    <= S_IDLE;
          end else begin
            discard <= 1'b1;
          end
        end
        default: ;
      endcase
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            o_wr_rd <= i_wr_rd;
            if (is_mem) begin
              o_wb_cyc <= 1'b1;
              o_wb_stb <= 1'b1;
              o_wb_we  <= i_opcode_store;
              o_wb_sel <= sel_next;
              o_ce     <= 1'b0;
              state    <= S_REQ;
            end else begin
              o_ce <= 1'b1;
            end
          end else if (!i_stall) begin
            o_ce <= 1'b0;
          end
        end
        S_REQ: begin
          if (!i_wb_stall) begin
            o_wb_stb <= 1'b0;
            if (!i_wb_ack) state <= S_WAIT;
          end
        end
        default: ;
      endcase
      if (bus_done) begin
        o_wb_cyc <= 1'b0;
        o_wb_we  <= 1'b0;
        discard  <= 1'b0;
        state    <= S_IDLE;
        if (!discard) begin
          o_ce <= 1'b1;
          if (o_opcode_load) o_data_load <= load_ext;
        end
      end
    end
  end

endmodule

// File: tb/tb_as_rv32i_memoryaccess.sv
// Bench for the memory-access stage: directed cases with literal values,
// then randomized traffic against a behavioural model of the stage.
module tb_as_rv32i_memoryaccess;

  logic        i_clk = 1'b0;
  logic        i_rst_n;
  logic [2:0]  i_funct3;
  logic        i_opcode_load, i_opcode_store, i_opcode_system;
  logic [31:0] i_y, i_rs2;
  logic        i_wr_rd;
  logic [4:0]  i_rd_addr;
  logic [31:0] i_rd, i_pc;
  logic [2:0]  o_funct3;
  logic        o_opcode_load, o_opcode_system, o_wr_rd;
  logic [4:0]  o_rd_addr;
  logic [31:0] o_rd, o_pc, o_data_load;
  logic        o_wb_cyc, o_wb_stb, o_wb_we;
  logic [31:0] o_wb_addr, o_wb_data;
  logic [3:0]  o_wb_sel;
  logic        i_wb_ack, i_wb_stall;
  logic [31:0] i_wb_data;
  logic        i_ce, o_ce, i_stall, o_stall, i_flush, o_flush;

  as_rv32i_memoryaccess dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_funct3(i_funct3),
    .i_opcode_load(i_opcode_load), .i_opcode_store(i_opcode_store),
    .i_opcode_system(i_opcode_system), .i_y(i_y), .i_rs2(i_rs2),
    .i_wr_rd(i_wr_rd), .i_rd_addr(i_rd_addr), .i_rd(i_rd), .i_pc(i_pc),
    .o_funct3(o_funct3), .o_opcode_load(o_opcode_load),
    .o_opcode_system(o_opcode_system), .o_wr_rd(o_wr_rd),
    .o_rd_addr(o_rd_addr), .o_rd(o_rd), .o_pc(o_pc), .o_data_load(o_data_load),
    .o_wb_cyc(o_wb_cyc), .o_wb_stb(o_wb_stb), .o_wb_we(o_wb_we),
    .o_wb_addr(o_wb_addr), .o_wb_data(o_wb_data), .o_wb_sel(o_wb_sel),
    .i_wb_ack(i_wb_ack), .i_wb_stall(i_wb_stall), .i_wb_data(i_wb_data),
    .i_ce(i_ce), .o_ce(o_ce), .i_stall(i_stall), .o_stall(o_stall),
    .i_flush(i_flush), .o_flush(o_flush)
  );

  always #5 i_clk = ~i_clk;

  int n_vec = 0;
  int n_err = 0;

  // Model: expected outputs after the next edge.
  logic        m_ce, m_wr_rd, m_cyc, m_stb, m_we, m_disc, m_opl, m_ops;
  logic [31:0] m_addr, m_data, m_dl, m_rd, m_pc;
  logic [3:0]  m_sel;
  logic [2:0]  m_f3;
  logic [4:0]  m_rd_addr;
  logic [1:0]  m_off;

  function automatic int size_of(input logic [2:0] f3);
    return 1 << f3[1:0];
  endfunction

  function automatic logic [3:0] sel_model(input logic [2:0] f3, input logic [1:0] a);
    int n, base, s;
    n = size_of(f3);
    base = (int'(a) / n) * n;
    s = ((1 << n) - 1) << base;
    return 4'(s);
  endfunction

  function automatic logic [31:0] lane_model(input logic [2:0] f3, input logic [31:0] rs2);
    int n;
    n = size_of(f3);
    if (n == 1) return {24'h0, rs2[7:0]} * 32'h01010101;
    if (n == 2) return {16'h0, rs2[15:0]} * 32'h00010001;
    return rs2;
  endfunction

  function automatic logic [31:0] ext_model(input logic [2:0] f3, input logic [1:0] a,
                                            input logic [31:0] w);
    int n, base;
    logic [31:0] v, span;
    n = size_of(f3);
    if (n == 4) return w;
    base = (int'(a) / n) * n;
    span = 32'(1) << (8 * n);
    v = (w >> (8 * base)) & (span - 32'd1);
    if (!f3[2] && v >= (span >> 1)) v = v - span;
    return v;
  endfunction

  task automatic model_edge();
    logic done;
    if (!i_rst_n) begin
      m_ce = 0; m_wr_rd = 0; m_cyc = 0; m_stb = 0; m_we = 0; m_disc = 0;
      m_dl = 32'h0; m_sel = 4'h0;
    end else if (i_flush) begin
      m_ce = 0; m_wr_rd = 0;
      if (m_stb) begin
        m_cyc = 0; m_stb = 0;
      end else if (m_cyc) begin
        if (i_wb_ack) begin m_cyc = 0; m_disc = 0; end
        else m_disc = 1;
      end
    end else if (!m_cyc) begin
      if (i_ce && !i_stall) begin
        m_f3 = i_funct3; m_opl = i_opcode_load; m_ops = i_opcode_system;
        m_rd_addr = i_rd_addr; m_rd = i_rd; m_pc = i_pc; m_wr_rd = i_wr_rd;
        if (i_opcode_load || i_opcode_store) begin
          m_cyc = 1; m_stb = 1; m_we = i_opcode_store; m_ce = 0;
          m_addr = i_y & 32'hFFFF_FFFC;
          m_sel  = sel_model(i_funct3, i_y[1:0]);
          m_data = lane_model(i_funct3, i_rs2);
          m_off  = i_y[1:0];
        end else begin
          m_ce = 1;
        end
      end else if (!i_stall) begin
        m_ce = 0;
      end
    end else begin
      done = 0;
      if (m_stb) begin
        if (!i_wb_stall) begin m_stb = 0; done = i_wb_ack; end
      end else begin
        done = i_wb_ack;
      end
      if (done) begin
        m_cyc = 0;
        if (!m_disc) begin
          m_ce = 1;
          if (m_opl) m_dl = ext_model(m_f3, m_off, i_wb_data);
        end
        m_disc = 0;
      end
    end
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic compare_all();
    check("o_ce", 32'(o_ce), 32'(m_ce));
    check("o_wr_rd", 32'(o_wr_rd), 32'(m_wr_rd));
    check("o_wb_cyc", 32'(o_wb_cyc), 32'(m_cyc));
    check("o_wb_stb", 32'(o_wb_stb), 32'(m_stb));
    check("o_wb_sel", 32'(o_wb_sel), 32'(m_sel));
    check("o_data_load", o_data_load, m_dl);
    check("o_stall", 32'(o_stall), 32'(i_stall | m_cyc));
    check("o_flush", 32'(o_flush), 32'(i_flush));
    if (m_cyc) begin
      check("o_wb_we", 32'(o_wb_we), 32'(m_we));
      check("o_wb_addr", o_wb_addr, m_addr);
      if (m_we) check("o_wb_data", o_wb_data, m_data);
    end
    if (m_ce) begin
      check("o_rd", o_rd, m_rd);
      check("o_pc", o_pc, m_pc);
      check("o_rd_addr", 32'(o_rd_addr), 32'(m_rd_addr));
      check("o_funct3", 32'(o_funct3), 32'(m_f3));
      check("o_opcode_load", 32'(o_opcode_load), 32'(m_opl));
      check("o_opcode_system", 32'(o_opcode_system), 32'(m_ops));
    end
  endtask

  task automatic step();
    model_edge();
    @(posedge i_clk);
    #1;
    compare_all();
  endtask

  task automatic quiet();
    i_ce = 0; i_flush = 0; i_stall = 0; i_wb_ack = 0; i_wb_stall = 0;
    i_opcode_load = 0; i_opcode_store = 0; i_opcode_system = 0;
  endtask

  // kind: 0 non-memory, 1 load, 2 store
  task automatic issue(input int kind, input logic [2:0] f3, input logic [31:0] y,
                       input logic [31:0] rs2);
    i_ce = 1; i_funct3 = f3; i_y = y; i_rs2 = rs2;
    i_opcode_load = (kind == 1); i_opcode_store = (kind == 2);
    i_opcode_system = 0; i_wr_rd = (kind != 2);
    i_rd_addr = 5'($urandom); i_rd = $urandom; i_pc = $urandom;
  endtask

  initial begin
    int hi;
    logic [2:0] ld_f3 [5] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
    quiet();
    i_rst_n = 0; i_funct3 = 0; i_y = 0; i_rs2 = 0; i_wr_rd = 0;
    i_rd_addr = 0; i_rd = 0; i_pc = 0; i_wb_data = 0;
    step(); step();
    check("reset o_ce", 32'(o_ce), 32'h0);
    check("reset o_wb_cyc", 32'(o_wb_cyc), 32'h0);
    i_rst_n = 1;
    step();

    // Non-memory instruction: one-cycle latency.
    issue(0, 3'b000, 32'h5, 32'h0); i_rd = 32'h1234;
    step(); quiet();
    check("add o_ce", 32'(o_ce), 32'h1);
    check("add o_rd", o_rd, 32'h1234);
    check("add o_wb_cyc", 32'(o_wb_cyc), 32'h0);
    step();

    // LB at 0x103, ack two cycles after strobe.
    issue(1, 3'b000, 32'h103, 32'h0);
    hi = 0;
    step(); quiet();
    check("lb sel", 32'(o_wb_sel), 32'h8);
    check("lb addr", o_wb_addr, 32'h100);
    hi += int'(o_stall);
    step(); hi += int'(o_stall);
    step(); hi += int'(o_stall);
    i_wb_ack = 1; i_wb_data = 32'h80FFFFFF;
    step(); i_wb_ack = 0; hi += int'(o_stall);
    check("lb stall cycles", 32'(hi), 32'd3);
    check("lb data", o_data_load, 32'hFFFFFF80);
    check("lb o_ce", 32'(o_ce), 32'h1);

    // LHU at 0x202, ack with the strobe.
    issue(1, 3'b101, 32'h202, 32'h0);
    step(); quiet();
    check("lhu sel", 32'(o_wb_sel), 32'hC);
    i_wb_ack = 1; i_wb_data = 32'hBEEF1234;
    step(); quiet();
    check("lhu data", o_data_load, 32'h0000BEEF);

    // LW with three bus-stall cycles.
    issue(1, 3'b010, 32'h40, 32'h0);
    step(); quiet();
    hi = int'(o_wb_stb);
    i_wb_stall = 1;
    for (int k = 0; k < 3; k++) begin step(); hi += int'(o_wb_stb); end
    i_wb_stall = 0; i_wb_ack = 1; i_wb_data = 32'hCAFEF00D;
    step(); quiet();
    check("lw stb cycles", 32'(hi), 32'd4);
    check("lw data", o_data_load, 32'hCAFEF00D);

    // SH at 0x06 and SB at 0x01.
    issue(2, 3'b001, 32'h6, 32'hAAAA5678);
    step(); quiet();
    check("sh we", 32'(o_wb_we), 32'h1);
    check("sh sel", 32'(o_wb_sel), 32'hC);
    check("sh data", o_wb_data, 32'h56785678);
    i_wb_ack = 1; step(); quiet();
    issue(2, 3'b000, 32'h1, 32'h12);
    step(); quiet();
    check("sb sel", 32'(o_wb_sel), 32'h2);
    check("sb data", o_wb_data, 32'h12121212);
    i_wb_ack = 1; step(); quiet();

    // Flush while the strobe is held off by the bus.
    issue(1, 3'b010, 32'h80, 32'h0);
    step(); quiet();
    i_wb_stall = 1; i_flush = 1;
    step(); quiet();
    check("flush req cyc", 32'(o_wb_cyc), 32'h0);
    check("flush req stb", 32'(o_wb_stb), 32'h0);
    step();
    check("flush req o_ce", 32'(o_ce), 32'h0);

    // Flush while waiting for the acknowledge.
    issue(1, 3'b010, 32'h84, 32'h0);
    step(); quiet();
    step();
    i_flush = 1; step(); quiet();
    check("flush wait cyc", 32'(o_wb_cyc), 32'h1);
    check("flush wait wr_rd", 32'(o_wr_rd), 32'h0);
    i_wb_ack = 1; i_wb_data = 32'h11111111;
    step(); quiet();
    check("flush wait done cyc", 32'(o_wb_cyc), 32'h0);
    check("flush wait o_ce", 32'(o_ce), 32'h0);

    // Reset in the middle of a wait.
    issue(1, 3'b010, 32'h88, 32'h0);
    step(); quiet();
    step();
    i_rst_n = 0; step(); i_rst_n = 1;
    check("rst cyc", 32'(o_wb_cyc), 32'h0);
    check("rst stb", 32'(o_wb_stb), 32'h0);
    check("rst o_ce", 32'(o_ce), 32'h0);
    check("rst o_stall", 32'(o_stall), 32'h0);

    // Randomized traffic against the model.
    for (int c = 0; c < 4000; c++) begin
      int kind;
      logic [2:0] f3;
      logic [31:0] y;
      i_rst_n = ($urandom_range(0, 199) != 0);
      i_flush = ($urandom_range(0, 19) == 0);
      i_stall = m_cyc ? 1'b0 : ($urandom_range(0, 6) == 0);
      kind = $urandom_range(0, 2);
      if (kind == 1) f3 = ld_f3[$urandom_range(0, 4)];
      else if (kind == 2) f3 = 3'($urandom_range(0, 2));
      else f3 = 3'($urandom);
      y = $urandom;
      if (kind != 0) begin
        if (size_of(f3) == 2) y[0] = 1'b0;
        if (size_of(f3) == 4) y[1:0] = 2'b00;
      end
      issue(kind, f3, y, $urandom);
      i_ce = ($urandom_range(0, 9) < 6);
      i_opcode_system = (kind == 0) ? 1'($urandom) : 1'b0;
      i_wb_data = $urandom;
      if (m_stb) begin
        i_wb_stall = ($urandom_range(0, 2) == 0);
        i_wb_ack = !i_wb_stall && ($urandom_range(0, 1) == 0);
      end else if (m_cyc) begin
        i_wb_stall = 1'($urandom);
        i_wb_ack = ($urandom_range(0, 1) == 0);
      end else begin
        i_wb_stall = 1'($urandom);
        i_wb_ack = 0;
      end
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
